preg_free_list: RTL and testbench
=================================

Name: preg_free_list

Overview:
- Circular free-list of physical register tags. It is the producer end of the rename stage's free-preg interface (`i_free_PRegs`).
- Each cycle it presents up to two free pregs to RENAME and pops the ones RENAME consumes.
- Each cycle it accepts up to two released pregs from the retire/COMPLETE side and pushes them back.
- It sits between COMPLETE (release) and RENAME (allocate).

Parameters:
- NUM_PREGS, 64, total physical registers; p_reg width = $clog2(NUM_PREGS).
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are identity-mapped at reset.
- DEPTH, NUM_PREGS-NUM_AREGS (32), free-list capacity; must be a power of 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- o_free_pregs  output  p_reg [0:1]  head and head+1 entries, driven combinationally from registered storage; drives RENAME i_free_PRegs.
- o_free_valid  output  1 [0:1]  o_free_valid[k] = (count > k).
- i_alloc_en  input  1 [0:1]  RENAME consumes slot k this cycle; legal patterns are 00, 10, 11.
- i_release_en  input  1 [0:1]  retire frees a preg in slot k.
- i_release_preg  input  p_reg [0:1]  preg being freed in slot k.
- o_count  output  $clog2(DEPTH+1)  number of free entries.
- o_stall  output  1  asserted when count < 2; RENAME must hold its bundle.
- o_error  output  1  sticky protocol-violation flag.

Behaviour:
- Storage:
  - mem[0:DEPTH-1] of p_reg, read pointer head, write pointer tail, both log2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - count is kept explicitly, so full and empty are unambiguous when head == tail.
- Reset (i_rst=1 at an edge):
  - mem[k] = NUM_AREGS+k; head=0; tail=0; count=DEPTH; o_error=0.
  - Following reset: o_free_pregs = {32,33}, o_free_valid = {1,1}, o_stall = 0.
  - Reset takes priority over every other input in the same cycle, including mid-operation.
- Allocation:
  - n_alloc = number of i_alloc_en bits set that are also valid.
  - head += n_alloc.
  - A request with i_alloc_en[k]=1 while o_free_valid[k]=0 is not granted, does not move head, and sets o_error.
  - Pattern 01 is treated as illegal: sets o_error, no pop.
- Release:
  - Valid slots are compacted in order: slot 0 is written at tail, then slot 1 at tail+1 (or at tail if slot 0 is idle).
  - tail += n_rel.
  - A release of preg 0 (the x0 mapping) is dropped and counts toward neither n_rel nor the tail advance.
  - A release that would make count exceed DEPTH is dropped and sets o_error.
- Simultaneous alloc and release in one cycle:
  - count_next = count + n_rel - n_alloc.
  - Overflow is checked against count - n_alloc, since pops are freed first.
  - A released preg is never visible on o_free_pregs in the same cycle it is released; it becomes visible no earlier than the next cycle.
  - An empty list plus a release gives no bypass: the preg appears the following cycle.
- Latency:
  - Allocation takes effect at the edge, and the new head is visible in the next cycle.
  - Release to allocatable takes 1 cycle minimum.
- Wrap-around:
  - head=DEPTH-1 with 2 allocs wraps head to 1.
  - o_free_pregs[1] reads mem[(head+1) mod DEPTH].
- o_error is cleared only by reset.
- No combinational path from i_alloc_en or i_release_* to any output.

Test Plan:
- Reset then idle
  - Stimulus: reset, then idle.
  - Required: o_free_pregs={32,33}, o_free_valid={1,1}, o_count=32, o_stall=0, o_error=0.
- Drain the list
  - Stimulus: alloc 11 for 16 cycles.
  - Required: pregs 32..63 handed out in order; o_count=0, o_stall=1, o_free_valid={0,0}.
  - A further alloc 11 sets o_error with count unchanged.
- Release after drain
  - Stimulus: after the drain, release {40,50} in one cycle.
  - Required: next cycle o_free_pregs={40,50}, o_count=2, o_stall=0.
  - Then release {0,7}: only 7 is pushed, o_count=3, no error.
- Simultaneous alloc and release across the wrap
  - Stimulus: head=31, count=2; same cycle alloc 11 and release {45,46}.
  - Required: head=1, count=2, o_free_pregs={45,46} next cycle, with correct wrap.
- Overflow
  - Stimulus: at count=32 (full), release {5,6} with no alloc.
  - Required: both dropped, o_error=1, contents unchanged.
  - Same full state with alloc 10 plus release 10 of preg 5: accepted, count stays 32, no error.
- Reset mid-operation
  - Stimulus: assert i_rst together with alloc 11 and release 11 at count=10.
  - Required: next cycle matches the reset state exactly, with o_error cleared.

Source files
------------

// File: rtl/preg_free_list.sv
// Circular free list of physical register tags feeding rename allocation.
// Up to two pops and two pushes per cycle; an explicit count separates full from empty.
module preg_free_list #(
    parameter  int unsigned NUM_PREGS = 64,
    parameter  int unsigned NUM_AREGS = 32,
    parameter  int unsigned DEPTH     = NUM_PREGS - NUM_AREGS,
    localparam int unsigned PREG_W    = $clog2(NUM_PREGS),
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [PREG_W-1:0] o_free_pregs [0:1],
    output logic [0:1]        o_free_valid,
    input  logic [0:1]        i_alloc_en,
    input  logic [0:1]        i_release_en,
    input  logic [PREG_W-1:0] i_release_preg [0:1],
    output logic [CNT_W-1:0]  o_count,
    output logic              o_stall,
    output logic              o_error
);

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  wr_ptr1;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  after_pop;
    logic [CNT_W-1:0]  room;
    logic [CNT_W-1:0]  n_alloc;
    logic [CNT_W-1:0]  n_rel;
    logic              grant0;
    logic              grant1;
    logic              alloc_err;
    logic              rel_req0;
    logic              rel_req1;
    logic              acc0;
    logic              acc1;
    logic              rel_err;
    logic              error;

    // Grant/accept decisions; releases see the room left after this cycle's pops.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        alloc_err  = 1'b0;
        rel_req0   = 1'b0;
        rel_req1   = 1'b0;
        acc0       = 1'b0;
        acc1       = 1'b0;
        rel_err    = 1'b0;
        n_alloc    = '0;
        n_rel      = '0;
        after_pop  = count;
        room       = '0;
        wr_ptr1    = tail;
        count_next = count;

        grant0    = i_alloc_en[0] && (count != '0);
        grant1    = i_alloc_en[0] && i_alloc_en[1] && (count > CNT_W'(1));
        alloc_err = (i_alloc_en[1] && !i_alloc_en[0])
                  || (i_alloc_en[0] && !grant0)
                  || (i_alloc_en[0] && i_alloc_en[1] && !grant1);
        n_alloc   = CNT_W'(grant0) + CNT_W'(grant1);
        after_pop = count - n_alloc;
        room      = CNT_W'(DEPTH) - after_pop;

        // preg 0 is the hardwired x0 mapping and never returns to the pool
        rel_req0 = i_release_en[0] && (i_release_preg[0] != '0);
        rel_req1 = i_release_en[1] && (i_release_preg[1] != '0);
        acc0     = rel_req0 && (room != '0);
        acc1     = rel_req1 && (room > CNT_W'(acc0));
        rel_err  = (rel_req0 && !acc0) || (rel_req1 && !acc1);
        n_rel    = CNT_W'(acc0) + CNT_W'(acc1);
        wr_ptr1  = tail + PTR_W'(acc0);

        count_next = after_pop + n_rel;
    end

    // Storage and pointer state; reset reloads the non-architectural pregs in order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[PTR_W'(k)] <= PREG_W'(NUM_AREGS + k);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            error <= 1'b0;
        end else begin
            if (acc0) mem[tail]    <= i_release_preg[0];
            if (acc1) mem[wr_ptr1] <= i_release_preg[1];
            head  <= head + PTR_W'(n_alloc);
            tail  <= tail + PTR_W'(n_rel);
            count <= count_next;
            if (alloc_err || rel_err) error <= 1'b1;
        end
    end

    assign o_free_pregs[0] = mem[head];
    assign o_free_pregs[1] = mem[head + PTR_W'(1)];
    assign o_free_valid    = {count != '0, count > CNT_W'(1)};
    assign o_count         = count;
    assign o_stall         = count < CNT_W'(2);
    assign o_error         = error;

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: directed vector table, hand-built wrap/reset sequences,
// then random traffic against a queue-based model of the free pool.
module tb_preg_free_list;

    localparam int unsigned DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] free_pregs [0:1];
    logic [0:1] free_valid;
    logic [0:1] alloc_en = '0;
    logic [0:1] release_en = '0;
    logic [5:0] release_preg [0:1];
    logic [5:0] count;
    logic       stall;
    logic       error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    preg_free_list dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_free_pregs   (free_pregs),
        .o_free_valid   (free_valid),
        .i_alloc_en     (alloc_en),
        .i_release_en   (release_en),
        .i_release_preg (release_preg),
        .o_count        (count),
        .o_stall        (stall),
        .o_error        (error)
    );

    typedef struct {
        bit         rst;
        logic [0:1] al;
        logic [0:1] re;
        int         r0;
        int         r1;
        int         ep0;
        int         ep1;
        logic [0:1] ev;
        int         ecnt;
        bit         eerr;
    } vec_t;

    vec_t tbl[$];

    // Reference pool: ordered list of free pregs plus sticky error.
    int m_q[$];
    bit m_err;

    function automatic vec_t mk(bit r, logic [0:1] al, logic [0:1] re, int r0, int r1,
                                int ep0, int ep1, int ecnt, bit eerr);
        vec_t v;
        v.rst = r; v.al = al; v.re = re; v.r0 = r0; v.r1 = r1;
        v.ep0 = ep0; v.ep1 = ep1; v.ecnt = ecnt; v.eerr = eerr;
        v.ev = {ecnt > 0, ecnt > 1};
        return v;
    endfunction

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_state(string tag, int ep0, int ep1, logic [0:1] ev, int ecnt, bit eerr);
        cmp({tag, " valid"}, int'(free_valid), int'(ev));
        cmp({tag, " count"}, int'(count), ecnt);
        cmp({tag, " stall"}, int'(stall), int'(ecnt < 2));
        cmp({tag, " error"}, int'(error), int'(eerr));
        if (ev[0]) cmp({tag, " preg0"}, int'(free_pregs[0]), ep0);
        if (ev[1]) cmp({tag, " preg1"}, int'(free_pregs[1]), ep1);
    endtask

    task automatic step(bit r, logic [0:1] al, logic [0:1] re, int p0, int p1);
        rst             = r;
        alloc_en        = al;
        release_en      = re;
        release_preg[0] = 6'(p0);
        release_preg[1] = 6'(p1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        alloc_en   = '0;
        release_en = '0;
    endtask

    task automatic model_step(bit r, logic [0:1] al, logic [0:1] re, int p0, int p1);
        int want;
        int rp[2];
        if (r) begin
            m_q = {};
            for (int k = 0; k < int'(DEPTH); k++) m_q.push_back(32 + k);
            m_err = 1'b0;
            return;
        end
        if (al == 2'b01) begin
            m_err = 1'b1;
        end else begin
            want = int'(al[0]) + int'(al[1]);
            if (want > m_q.size()) m_err = 1'b1;
            for (int k = 0; k < want; k++) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
            end
        end
        rp[0] = p0;
        rp[1] = p1;
        for (int k = 0; k < 2; k++) begin
            if (re[k] && rp[k] != 0) begin
                if (m_q.size() < int'(DEPTH)) m_q.push_back(rp[k]);
                else m_err = 1'b1;
            end
        end
    endtask

    initial begin
        release_preg[0] = '0;
        release_preg[1] = '0;

        // Directed table: reset, drain, refill, empty/partial over-alloc, overflow, illegal 01.
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32, 33, 32, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 32, 33, 32, 0));
        for (int i = 0; i < 16; i++) begin
            int n;
            n = 2 * (i + 1);
            tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 32 + n, 33 + n, 32 - n, 0));
        end
        tbl.push_back(mk(0, 2'b00, 2'b11, 40, 50, 40, 50, 2, 0));
        tbl.push_back(mk(0, 2'b00, 2'b11, 0, 7, 40, 50, 3, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 7, 0, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32, 33, 32, 0));
        tbl.push_back(mk(0, 2'b00, 2'b11, 5, 6, 32, 33, 32, 1));
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32, 33, 32, 0));
        tbl.push_back(mk(0, 2'b10, 2'b10, 5, 0, 33, 34, 32, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 33, 34, 32, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].al, tbl[i].re, tbl[i].r0, tbl[i].r1);
            check_state($sformatf("vec%0d", i), tbl[i].ep0, tbl[i].ep1, tbl[i].ev,
                        tbl[i].ecnt, tbl[i].eerr);
        end

        // Wrap: head reaches DEPTH-1 with one entry, then a dual pop/push straddles the wrap.
        step(1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 2'b11, 2'b00, 0, 0);
        step(0, 2'b10, 2'b00, 0, 0);
        check_state("wrap_h31", 63, 0, 2'b10, 1, 0);
        step(0, 2'b00, 2'b10, 20, 0);
        check_state("wrap_rd", 63, 20, 2'b11, 2, 0);
        step(0, 2'b11, 2'b11, 45, 46);
        check_state("wrap_both", 45, 46, 2'b11, 2, 0);
        step(0, 2'b10, 2'b00, 0, 0);
        check_state("wrap_pop", 46, 0, 2'b10, 1, 0);

        // Reset wins over simultaneous traffic and clears a pending error.
        step(1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 2'b11, 2'b00, 0, 0);
        step(0, 2'b01, 2'b00, 0, 0);
        check_state("mid_pre", 54, 55, 2'b11, 10, 1);
        step(1, 2'b11, 2'b11, 3, 4);
        check_state("mid_rst", 32, 33, 2'b11, 32, 0);

        // Random traffic with alternating drain-heavy and fill-heavy phases.
        model_step(1, 2'b00, 2'b00, 0, 0);
        step(1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit         r;
            logic [0:1] al;
            logic [0:1] re;
            int         p0;
            int         p1;
            int         sel;
            bit         drain;
            drain = ((i / 60) % 2) == 0;
            r     = ($urandom_range(0, 199) == 0);
            sel   = $urandom_range(0, 19);
            if (sel == 0)                      al = 2'b01;
            else if (sel < (drain ? 13 : 5))   al = 2'b11;
            else if (sel < (drain ? 17 : 10))  al = 2'b10;
            else                               al = 2'b00;
            re = 2'($urandom_range(0, 3));
            if (drain && $urandom_range(0, 2) != 0) re = 2'b00;
            p0 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63);
            p1 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63);
            model_step(r, al, re, p0, p1);
            step(r, al, re, p0, p1);
            check_state($sformatf("rnd%0d", i),
                        (m_q.size() > 0) ? m_q[0] : 0,
                        (m_q.size() > 1) ? m_q[1] : 0,
                        {m_q.size() > 0, m_q.size() > 1}, m_q.size(), m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
